// File: rtl/wr_ptr_ctrl_p_pkg.sv
// Shared types and Gray/binary helpers for the asynchronous FIFO write-side controller.
// Helpers work on a wide word; callers zero-extend their pointer and truncate the result.
package wr_ptr_ctrl_p_pkg;

    localparam int unsigned PtrWordW = 32;

    typedef logic [PtrWordW-1:0] ptr_word_t;

    // DROP_MODE encodings
    localparam int unsigned DropModeOff = 0;
    localparam int unsigned DropModeOn  = 1;

    function automatic ptr_word_t bin2gray(input ptr_word_t b);
        return b ^ (b >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at or above it.
    function automatic ptr_word_t gray2bin(input ptr_word_t g);
        ptr_word_t b;
        b = g;
        for (int i = 1; i < PtrWordW; i++) begin
            b = b ^ (g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/wr_ptr_ctrl_p_if.sv
// Write-side handshake and dual-port RAM write port of the FIFO controller.
interface wr_ptr_ctrl_p_if #(
    parameter int unsigned ADDR_W = 3
) ();

    logic              ivalid;
    logic              iready;
    logic              wen;
    logic [ADDR_W-1:0] waddr;

    modport master (
        output ivalid,
        input  iready,
        input  wen,
        input  waddr
    );

    modport slave (
        input  ivalid,
        output iready,
        output wen,
        output waddr
    );

endinterface

// File: rtl/wr_ptr_ctrl_p_gray_sync.sv
// Multi-flop synchroniser for a Gray-coded pointer crossing into the local clock domain.
// Reset is synchronous and active-low so the chain clears together with the pointer logic.
module wr_ptr_ctrl_p_gray_sync #(
    parameter int unsigned W      = 4,
    parameter int unsigned STAGES = 2
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [STAGES-1:0][W-1:0] sync_q;
    logic [STAGES-1:0][W-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], d_i};
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/wr_ptr_ctrl_p.sv
// Write-clock-domain controller of the asynchronous FIFO: write pointer, read-pointer sync,
// full/almost-full/level generation, RAM write port and optional drop-while-full mode.
module wr_ptr_ctrl_p
    import wr_ptr_ctrl_p_pkg::*;
#(
    parameter int unsigned ADDR_W       = 3,
    parameter int unsigned SYNC_STAGES  = 2,
    parameter int unsigned AFULL_THRESH = 6,
    parameter int unsigned DROP_MODE    = 0,
    parameter int unsigned DROP_CNT_W   = 8
) (
    input  logic                  clkin,
    input  logic                  rstin,
    wr_ptr_ctrl_p_if.slave        wr_if,
    input  logic [ADDR_W:0]       rptr_gray_i,
    output logic [ADDR_W:0]       wptr_gray_o,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_W:0]       wlevel,
    output logic [DROP_CNT_W-1:0] drop_cnt
);

    typedef logic [ADDR_W:0]       ptr_t;
    typedef logic [DROP_CNT_W-1:0] cnt_t;

    // Full when the write pointer is exactly one lap ahead: top two Gray bits inverted.
    localparam ptr_t FullMask = {2'b11, {(ADDR_W-1){1'b0}}};

    ptr_t wbin_q, wbin_d;
    ptr_t wgray_q, wgray_d;
    ptr_t level_q, level_d;
    logic full_q, full_d;
    logic afull_q, afull_d;
    cnt_t drop_cnt_q, drop_cnt_d;

    ptr_t rsync;
    ptr_t rbin;
    logic accept;
    logic drop;

    wr_ptr_ctrl_p_gray_sync #(
        .W      (ADDR_W + 1),
        .STAGES (SYNC_STAGES)
    ) u_rptr_sync (
        .clk_i  (clkin),
        .rst_ni (rstin),
        .d_i    (rptr_gray_i),
        .q_o    (rsync)
    );

    always_comb begin
        accept = wr_if.ivalid & ~full_q & rstin;
        drop   = (DROP_MODE == DropModeOn) && wr_if.ivalid && full_q && rstin;

        wbin_d  = accept ? wbin_q + ptr_t'(1) : wbin_q;
        wgray_d = ptr_t'(bin2gray(ptr_word_t'(wbin_d)));
        rbin    = ptr_t'(gray2bin(ptr_word_t'(rsync)));

        // Stale rsync can only lag the true read pointer, so the level never under-reports.
        level_d = wbin_d - rbin;
        full_d  = (wgray_d == (rsync ^ FullMask));
        afull_d = ptr_word_t'(level_d) >= ptr_word_t'(AFULL_THRESH);

        drop_cnt_d = drop_cnt_q;
        if (DROP_MODE == DropModeOff) begin
            drop_cnt_d = '0;
        end else if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + cnt_t'(1);
        end
    end

    always_ff @(posedge clkin) begin
        if (!rstin) begin
            wbin_q     <= '0;
            wgray_q    <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            afull_q    <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            wbin_q     <= wbin_d;
            wgray_q    <= wgray_d;
            level_q    <= level_d;
            full_q     <= full_d;
            afull_q    <= afull_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign wr_if.iready = (DROP_MODE == DropModeOn) ? rstin : (rstin & ~full_q);
    assign wr_if.wen    = accept;
    assign wr_if.waddr  = wbin_q[ADDR_W-1:0];

    assign wptr_gray_o = wgray_q;
    assign full        = full_q;
    assign almost_full = afull_q;
    assign wlevel      = level_q;
    assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_wr_ptr_ctrl_p.sv
// Bench for wr_ptr_ctrl_p: back-pressure instance and drop-mode instance, write-address scoreboard.
module tb_wr_ptr_ctrl_p;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst0_n, rst1_n;
    logic [3:0] rptr0, rptr1;
    logic [3:0] wgray0, wgray1;
    logic       full0, full1, afull0, afull1;
    logic [3:0] wlevel0, wlevel1;
    logic [7:0] drop0;
    logic [2:0] drop1;

    wr_ptr_ctrl_p_if #(.ADDR_W(3)) if0 ();
    wr_ptr_ctrl_p_if #(.ADDR_W(3)) if1 ();

    wr_ptr_ctrl_p #(
        .ADDR_W(3), .SYNC_STAGES(2), .AFULL_THRESH(6), .DROP_MODE(0), .DROP_CNT_W(8)
    ) dut0 (
        .clkin       (clk),
        .rstin       (rst0_n),
        .wr_if       (if0),
        .rptr_gray_i (rptr0),
        .wptr_gray_o (wgray0),
        .full        (full0),
        .almost_full (afull0),
        .wlevel      (wlevel0),
        .drop_cnt    (drop0)
    );

    wr_ptr_ctrl_p #(
        .ADDR_W(3), .SYNC_STAGES(2), .AFULL_THRESH(6), .DROP_MODE(1), .DROP_CNT_W(3)
    ) dut1 (
        .clkin       (clk),
        .rstin       (rst1_n),
        .wr_if       (if1),
        .rptr_gray_i (rptr1),
        .wptr_gray_o (wgray1),
        .full        (full1),
        .almost_full (afull1),
        .wlevel      (wlevel1),
        .drop_cnt    (drop1)
    );

    int total = 0;
    int bad   = 0;
    int exp0_q[$];
    int exp1_q[$];
    int wen1_cnt = 0;
    int m_wbin0  = 0;

    function automatic logic [3:0] tb_gray(input int b);
        logic [3:0] x;
        x = b[3:0];
        return x ^ (x >> 1);
    endfunction

    // Scoreboards: every observed write must match the next expected address.
    always @(negedge clk) begin
        int e;
        logic [2:0] ea;
        if (if0.wen === 1'b1) begin
            total++;
            if (exp0_q.size() == 0) begin
                bad++;
                $display("FAIL sb0_unexpected_wen: got write to waddr=%0d, required no write",
                         if0.waddr);
            end else begin
                e  = exp0_q.pop_front();
                ea = e[2:0];
                if (if0.waddr !== ea) begin
                    bad++;
                    $display("FAIL sb0_waddr: got %0d required %0d", if0.waddr, ea);
                end
            end
        end
        if (if1.wen === 1'b1) begin
            wen1_cnt++;
            total++;
            if (exp1_q.size() == 0) begin
                bad++;
                $display("FAIL sb1_unexpected_wen: got write to waddr=%0d, required no write",
                         if1.waddr);
            end else begin
                e  = exp1_q.pop_front();
                ea = e[2:0];
                if (if1.waddr !== ea) begin
                    bad++;
                    $display("FAIL sb1_waddr: got %0d required %0d", if1.waddr, ea);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic reset0();
        rst0_n     = 1'b0;
        if0.ivalid = 1'b0;
        rptr0      = '0;
        tick();
        rst0_n  = 1'b1;
        m_wbin0 = 0;
    endtask

    task automatic write0();
        if0.ivalid = 1'b1;
        exp0_q.push_back(m_wbin0 % 8);
        m_wbin0 = (m_wbin0 + 1) % 16;
    endtask

    task automatic test_reset();
        rst0_n = 1'b0; if0.ivalid = 1'b1; rptr0 = '0;
        rst1_n = 1'b0; if1.ivalid = 1'b1; rptr1 = '0;
        #1;
        total++; if (if0.iready !== 1'b0) begin bad++; $display("FAIL rst_iready0: got %b required 0", if0.iready); end
        total++; if (if0.wen !== 1'b0) begin bad++; $display("FAIL rst_wen0: got %b required 0", if0.wen); end
        total++; if (if1.iready !== 1'b0) begin bad++; $display("FAIL rst_iready1: got %b required 0", if1.iready); end
        total++; if (if1.wen !== 1'b0) begin bad++; $display("FAIL rst_wen1: got %b required 0", if1.wen); end
        tick();
        total++; if (wgray0 !== 4'd0) begin bad++; $display("FAIL rst_wgray0: got %b required 0000", wgray0); end
        total++; if (full0 !== 1'b0) begin bad++; $display("FAIL rst_full0: got %b required 0", full0); end
        total++; if (afull0 !== 1'b0) begin bad++; $display("FAIL rst_afull0: got %b required 0", afull0); end
        total++; if (wlevel0 !== 4'd0) begin bad++; $display("FAIL rst_wlevel0: got %0d required 0", wlevel0); end
        total++; if (drop0 !== 8'd0) begin bad++; $display("FAIL rst_drop0: got %0d required 0", drop0); end
        total++; if (if0.waddr !== 3'd0) begin bad++; $display("FAIL rst_waddr0: got %0d required 0", if0.waddr); end
        total++; if (drop1 !== 3'd0) begin bad++; $display("FAIL rst_drop1: got %0d required 0", drop1); end
        if0.ivalid = 1'b0; if1.ivalid = 1'b0;
        rst0_n = 1'b1; rst1_n = 1'b1;
        m_wbin0 = 0;
        #1;
        total++; if (if0.iready !== 1'b1) begin bad++; $display("FAIL rel_iready0: got %b required 1", if0.iready); end
        total++; if (if1.iready !== 1'b1) begin bad++; $display("FAIL rel_iready1: got %b required 1", if1.iready); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 8; i++) begin
            write0();
            #1;
            total++; if (if0.iready !== 1'b1) begin bad++; $display("FAIL fill_iready[%0d]: got %b required 1", i, if0.iready); end
            tick();
            total++; if (wlevel0 !== 4'(i + 1)) begin bad++; $display("FAIL fill_wlevel[%0d]: got %0d required %0d", i, wlevel0, i + 1); end
            total++; if (full0 !== (i == 7)) begin bad++; $display("FAIL fill_full[%0d]: got %b required %b", i, full0, i == 7); end
        end
        if0.ivalid = 1'b1;
        #1;
        total++; if (if0.iready !== 1'b0) begin bad++; $display("FAIL full_iready: got %b required 0", if0.iready); end
        total++; if (if0.wen !== 1'b0) begin bad++; $display("FAIL full_wen: got %b required 0", if0.wen); end
        tick();
        if0.ivalid = 1'b0;
        total++; if (wlevel0 !== 4'd8) begin bad++; $display("FAIL held_wlevel: got %0d required 8", wlevel0); end
        total++; if (wgray0 !== tb_gray(8)) begin bad++; $display("FAIL held_wgray: got %b required %b", wgray0, tb_gray(8)); end
        total++; if (full0 !== 1'b1) begin bad++; $display("FAIL held_full: got %b required 1", full0); end
    endtask

    task automatic test_drain();
        rptr0 = 4'b0001;
        for (int k = 1; k <= 3; k++) begin
            tick();
            if (k < 3) begin
                total++; if (full0 !== 1'b1) begin bad++; $display("FAIL drain_early_full[%0d]: got %b required 1", k, full0); end
            end
        end
        total++; if (full0 !== 1'b0) begin bad++; $display("FAIL drain_full: got %b required 0", full0); end
        total++; if (wlevel0 !== 4'd7) begin bad++; $display("FAIL drain_wlevel: got %0d required 7", wlevel0); end
        total++; if (if0.iready !== 1'b1) begin bad++; $display("FAIL drain_iready: got %b required 1", if0.iready); end
        write0();
        tick();
        if0.ivalid = 1'b0;
        total++; if (full0 !== 1'b1) begin bad++; $display("FAIL refill_full: got %b required 1", full0); end
        total++; if (wlevel0 !== 4'd8) begin bad++; $display("FAIL refill_wlevel: got %0d required 8", wlevel0); end
    endtask

    task automatic test_almost_full();
        reset0();
        for (int i = 0; i < 6; i++) begin
            write0();
            tick();
            if (i == 4) begin
                total++; if (afull0 !== 1'b0) begin bad++; $display("FAIL afull_5: got %b required 0", afull0); end
            end
        end
        if0.ivalid = 1'b0;
        total++; if (afull0 !== 1'b1) begin bad++; $display("FAIL afull_6: got %b required 1", afull0); end
        rptr0 = 4'b0001;
        tick(); tick();
        total++; if (afull0 !== 1'b1) begin bad++; $display("FAIL afull_lag: got %b required 1", afull0); end
        tick();
        total++; if (afull0 !== 1'b0) begin bad++; $display("FAIL afull_drop: got %b required 0", afull0); end
        total++; if (wlevel0 !== 4'd5) begin bad++; $display("FAIL afull_wlevel: got %0d required 5", wlevel0); end
    endtask

    task automatic test_wrap();
        logic [3:0] prev;
        int m_rbin;
        reset0();
        prev   = 4'd0;
        m_rbin = 0;
        for (int i = 0; i < 20; i++) begin
            write0();
            tick();
            total++; if (wgray0 !== tb_gray(m_wbin0)) begin bad++; $display("FAIL wrap_gray[%0d]: got %b required %b", i, wgray0, tb_gray(m_wbin0)); end
            total++; if ($countones(wgray0 ^ prev) != 1) begin bad++; $display("FAIL wrap_onebit[%0d]: got %b after %b, required one-bit change", i, wgray0, prev); end
            total++; if (full0 !== 1'b0) begin bad++; $display("FAIL wrap_full[%0d]: got %b required 0", i, full0); end
            if (i == 7) begin
                total++; if (wgray0[3] !== 1'b1) begin bad++; $display("FAIL wrap_bit_set: got %b required 1", wgray0[3]); end
            end
            if (i == 15) begin
                total++; if (wgray0[3] !== 1'b0) begin bad++; $display("FAIL wrap_bit_clr: got %b required 0", wgray0[3]); end
            end
            prev = wgray0;
            if (i >= 1) m_rbin = i - 1;
            rptr0 = tb_gray(m_rbin);
        end
        if0.ivalid = 1'b0;
        tick(); tick(); tick();
        total++; if (wlevel0 !== 4'd2) begin bad++; $display("FAIL wrap_wlevel: got %0d required 2", wlevel0); end
    endtask

    task automatic test_reset_mid();
        reset0();
        for (int i = 0; i < 5; i++) begin
            write0();
            tick();
        end
        rst0_n = 1'b0;
        if0.ivalid = 1'b1;
        #1;
        total++; if (if0.iready !== 1'b0) begin bad++; $display("FAIL mid_iready: got %b required 0", if0.iready); end
        total++; if (if0.wen !== 1'b0) begin bad++; $display("FAIL mid_wen: got %b required 0", if0.wen); end
        tick();
        total++; if (wgray0 !== 4'd0) begin bad++; $display("FAIL mid_wgray: got %b required 0000", wgray0); end
        total++; if (wlevel0 !== 4'd0) begin bad++; $display("FAIL mid_wlevel: got %0d required 0", wlevel0); end
        total++; if (if0.waddr !== 3'd0) begin bad++; $display("FAIL mid_waddr: got %0d required 0", if0.waddr); end
        total++; if (full0 !== 1'b0 || afull0 !== 1'b0) begin bad++; $display("FAIL mid_flags: got full=%b afull=%b required 0 0", full0, afull0); end
        rst0_n = 1'b1;
        if0.ivalid = 1'b0;
        m_wbin0 = 0;
        #1;
        total++; if (if0.iready !== 1'b1) begin bad++; $display("FAIL mid_rel_iready: got %b required 1", if0.iready); end
        write0();
        tick();
        if0.ivalid = 1'b0;
        total++; if (wlevel0 !== 4'd1) begin bad++; $display("FAIL mid_post_wlevel: got %0d required 1", wlevel0); end
    endtask

    task automatic test_drop();
        rptr1 = '0;
        for (int i = 0; i < 10; i++) begin
            if1.ivalid = 1'b1;
            if (i < 8) exp1_q.push_back(i);
            #1;
            total++; if (if1.iready !== 1'b1) begin bad++; $display("FAIL drop_iready[%0d]: got %b required 1", i, if1.iready); end
            tick();
        end
        total++; if (drop1 !== 3'd2) begin bad++; $display("FAIL drop_cnt: got %0d required 2", drop1); end
        total++; if (wen1_cnt != 8) begin bad++; $display("FAIL drop_wen_pulses: got %0d required 8", wen1_cnt); end
        total++; if (wgray1 !== tb_gray(8)) begin bad++; $display("FAIL drop_wgray: got %b required %b", wgray1, tb_gray(8)); end
        total++; if (wlevel1 !== 4'd8 || full1 !== 1'b1) begin bad++; $display("FAIL drop_level: got wlevel=%0d full=%b required 8 1", wlevel1, full1); end
        for (int i = 0; i < 8; i++) begin
            #1;
            total++; if (if1.iready !== 1'b1) begin bad++; $display("FAIL sat_iready[%0d]: got %b required 1", i, if1.iready); end
            tick();
        end
        if1.ivalid = 1'b0;
        total++; if (drop1 !== 3'd7) begin bad++; $display("FAIL drop_sat: got %0d required 7", drop1); end
        total++; if (wen1_cnt != 8) begin bad++; $display("FAIL sat_wen_pulses: got %0d required 8", wen1_cnt); end
    endtask

    initial begin
        if0.ivalid = 1'b0;
        if1.ivalid = 1'b0;
        test_reset();
        test_fill();
        test_drain();
        test_almost_full();
        test_wrap();
        test_reset_mid();
        test_drop();
        tick();
        total++; if (exp0_q.size() != 0) begin bad++; $display("FAIL sb0_left: got %0d pending writes required 0", exp0_q.size()); end
        total++; if (exp1_q.size() != 0) begin bad++; $display("FAIL sb1_left: got %0d pending writes required 0", exp1_q.size()); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
